// File: rtl/green_cube_pkg.sv
// Shared types and constants for the green cube player logic.
// Holds the jump state encoding, speed tiers and screen defaults.
package green_cube_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2,
        DEAD   = 2'd3
    } jump_state_t;

    localparam logic [8:0] TIER1    = 9'd80;
    localparam logic [8:0] TIER2    = 9'd160;
    localparam logic [8:0] TIER3    = 9'd240;
    localparam logic [8:0] TIER_END = 9'd320;

    localparam logic [9:0] DEF_CEILING_Y = 10'd100;
    localparam logic [9:0] DEF_BOTTOM_Y  = 10'd480;
    localparam logic [9:0] DEF_START_Y   = 10'd310;

    // Rising slows down tier by tier: 1, 1/2, 1/4, 1/8 px per clk.
    function automatic logic rise_step(input logic [8:0] tg);
        logic s;
        if (tg < TIER1)
            s = 1'b1;
        else if (tg < TIER2)
            s = ~tg[0];
        else if (tg < TIER3)
            s = (tg[1:0] == 2'b00);
        else
            s = (tg[2:0] == 3'b000);
        return s;
    endfunction

    // Falling speeds up tier by tier: 1/8, 1/4, 1/2, 1 px per clk.
    function automatic logic fall_step(input logic [8:0] tg);
        logic s;
        if (tg < TIER1)
            s = (tg[2:0] == 3'b000);
        else if (tg < TIER2)
            s = (tg[1:0] == 2'b00);
        else if (tg < TIER3)
            s = ~tg[0];
        else
            s = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/player_jump_ctrl_floor_contact.sv
// Four-floor landing detector with lowest-index priority.
// Also reports whether the floor currently stood on still supports the cube.
module floor_contact
    import green_cube_pkg::*;
#(
    parameter logic [9:0] PLAYER_SIZE = 10'd20,
    parameter logic [9:0] FLOOR_W     = 10'd100
) (
    input  logic [9:0]      player_x,
    input  logic [9:0]      player_y,
    input  logic [3:0][9:0] floor_x,
    input  logic [3:0][9:0] floor_y,
    input  logic [3:0]      enable,
    input  logic [1:0]      ground_idx,
    output logic            contact,
    output logic [1:0]      contact_idx,
    output logic            support
);

    logic [10:0] px_end;
    logic [10:0] py_end;
    logic [3:0]  x_ov;
    logic [3:0]  hit;

    assign px_end = {1'b0, player_x} + {1'b0, PLAYER_SIZE};
    assign py_end = {1'b0, player_y} + {1'b0, PLAYER_SIZE};

    // Per-floor horizontal overlap and exact top-edge touch.
    always_comb begin
        x_ov = '0;
        hit  = '0;
        for (int i = 0; i < 4; i++) begin
            x_ov[i] = enable[i]
                   && (px_end > {1'b0, floor_x[i]})
                   && ({1'b0, player_x} < ({1'b0, floor_x[i]} + {1'b0, FLOOR_W}));
            hit[i]  = x_ov[i] && (py_end == {1'b0, floor_y[i]});
        end
    end

    // Lowest touching floor index wins.
    always_comb begin
        contact     = |hit;
        contact_idx = 2'd0;
        if (hit[0])
            contact_idx = 2'd0;
        else if (hit[1])
            contact_idx = 2'd1;
        else if (hit[2])
            contact_idx = 2'd2;
        else if (hit[3])
            contact_idx = 2'd3;
    end

    assign support = x_ov[ground_idx];

endmodule

// File: rtl/player_jump_ctrl.sv
// Ground/rise/fall/dead vertical controller for the player cube.
// PLAYER_DOUBLE_JUMP_EN adds one mid-air jump per landing.
module player_jump_ctrl
    import green_cube_pkg::*;
#(
    parameter logic [9:0] PLAYER_SIZE = 10'd20,
    parameter logic [9:0] FLOOR_W     = 10'd100,
    parameter logic [9:0] CEILING_Y   = DEF_CEILING_Y,
    parameter logic [9:0] BOTTOM_Y    = DEF_BOTTOM_Y,
    parameter logic [9:0] START_Y     = DEF_START_Y
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       jump,
    input  logic [9:0] player_x,
    input  logic [9:0] floor_pos_x0,
    input  logic [9:0] floor_pos_x1,
    input  logic [9:0] floor_pos_x2,
    input  logic [9:0] floor_pos_x3,
    input  logic [9:0] floor_pos_y0,
    input  logic [9:0] floor_pos_y1,
    input  logic [9:0] floor_pos_y2,
    input  logic [9:0] floor_pos_y3,
    input  logic [3:0] enable,
    output logic [9:0] player_y,
    output logic [8:0] time_gap,
    output logic       hit_ceiling,
    output logic [1:0] state,
    output logic       dead
);

    jump_state_t     st_q, st_d;
    logic [9:0]      y_d;
    logic [8:0]      tg_d;
    logic [1:0]      gi_q, gi_d;
    logic [3:0][9:0] fx, fy;
    logic            contact, support, bottom, dj_ok;
    logic [1:0]      contact_idx;

    assign fx = {floor_pos_x3, floor_pos_x2, floor_pos_x1, floor_pos_x0};
    assign fy = {floor_pos_y3, floor_pos_y2, floor_pos_y1, floor_pos_y0};

    floor_contact #(
        .PLAYER_SIZE(PLAYER_SIZE),
        .FLOOR_W    (FLOOR_W)
    ) u_contact (
        .player_x   (player_x),
        .player_y   (player_y),
        .floor_x    (fx),
        .floor_y    (fy),
        .enable     (enable),
        .ground_idx (gi_q),
        .contact    (contact),
        .contact_idx(contact_idx),
        .support    (support)
    );

    assign bottom = ({1'b0, player_y} + {1'b0, PLAYER_SIZE}) >= {1'b0, BOTTOM_Y};

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic tok_q, tok_d;

    assign dj_ok = jump & tok_q;

    // Token is spent by a mid-air jump and refilled on landing.
    always_comb begin
        tok_d = tok_q;
        if (st_q == FALL && contact)
            tok_d = 1'b1;
        else if (st_q == FALL && dj_ok)
            tok_d = 1'b0;
    end

    // Token register.
    always_ff @(posedge clk) begin
        if (rst)
            tok_q <= 1'b1;
        else
            tok_q <= tok_d;
    end
`else
    assign dj_ok = 1'b0;
`endif

    // Next state, position and phase counter.
    always_comb begin
        st_d = st_q;
        y_d  = player_y;
        tg_d = time_gap;
        gi_d = gi_q;
        unique case (st_q)
            GROUND: begin
                tg_d = '0;
                y_d  = fy[gi_q] - PLAYER_SIZE;
                if (jump) begin
                    st_d = RISE;
                    tg_d = 9'd1;
                end else if (!support) begin
                    st_d = FALL;
                    tg_d = 9'd1;
                end
            end
            RISE: begin
                if (time_gap == TIER_END) begin
                    st_d = FALL;
                    tg_d = 9'd1;
                end else begin
                    tg_d = time_gap + 9'd1;
                    // At the ceiling the floors scroll instead.
                    if (rise_step(time_gap) && player_y != CEILING_Y)
                        y_d = player_y - 10'd1;
                end
            end
            FALL: begin
                if (contact) begin
                    st_d = GROUND;
                    tg_d = '0;
                    gi_d = contact_idx;
                end else if (dj_ok) begin
                    st_d = RISE;
                    tg_d = 9'd1;
                end else if (bottom) begin
                    st_d = DEAD;
                end else begin
                    if (time_gap != TIER_END)
                        tg_d = time_gap + 9'd1;
                    if (fall_step(time_gap))
                        y_d = player_y + 10'd1;
                end
            end
            DEAD: begin
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= GROUND;
            player_y <= START_Y;
            time_gap <= '0;
            gi_q     <= 2'd0;
        end else begin
            st_q     <= st_d;
            player_y <= y_d;
            time_gap <= tg_d;
            gi_q     <= gi_d;
        end
    end

    assign hit_ceiling = (st_q == RISE) && (player_y == CEILING_Y)
                      && (time_gap != '0) && (time_gap < TIER_END);
    assign state       = st_q;
    assign dead        = (st_q == DEAD);

endmodule
